ahb_wrr_output_arbiter: RTL and testbench
=========================================

# ahb_wrr_output_arbiter

Weighted round-robin output arbiter for one bus-matrix output stage. It selects which of up to eight input ports drives the shared slave. Each grant carries a per-port credit budget, measured in NONSEQ transfers, so a high-bandwidth master can own the slave for several transfers before rotation. Fixed-length bursts, short INCR bursts and locked sequences are never split. It sits between the input-stage request lines and the output-stage address/data muxes, driving the mux select and the idle indication.

## Interface
- NUM_PORTS, 4, number of input ports; legal range 2..8.
- PORT_W, 3, width of port index; must satisfy 2^PORT_W >= NUM_PORTS.
- WEIGHT_W, 4, width of each per-port weight field.
- HCLK  input  1  AHB clock; all state on rising edge.
- HRESETn  input  1  asynchronous, active-low reset.
- req  input  NUM_PORTS  per-port request; bit i from input port i.
- weight_cfg  input  NUM_PORTS*WEIGHT_W  static weights; field i at [i*WEIGHT_W +: WEIGHT_W].
- HREADYM  input  1  output-stage HREADY; gates every register update.
- HSELM  input  1  current owner still selects this slave.
- HTRANSM  input  2  current owner transfer type.
- HBURSTM  input  3  current owner burst type.
- HMASTLOCKM  input  1  current owner locked.
- addr_in_port  output  PORT_W  index of the granted input port.
- no_port  output  1  no port granted; the output stage drives IDLE.
- credit_remain  output  WEIGHT_W+1  owner's remaining NONSEQ credits, for debug.

## Operation
- Reset values: addr_in_port=0, no_port=1, credit_remain=0, burst_remain=0, burst_hold=0.
- Burst counter, computed combinationally to next_burst_remain/next_burst_hold:
  - HSELM=0 or IDLE: remain 0, hold 0.
  - NONSEQ with WRAP16/INCR16: remain 14, hold 1.
  - NONSEQ with WRAP8/INCR8: remain 6, hold 1.
  - NONSEQ with WRAP4/INCR4/INCR: remain 2, hold 1.
  - NONSEQ with SINGLE: remain 0, hold 0.
  - SEQ: if remain=0, hold 0; else remain-1 and hold kept.
  - BUSY: no change.
- Credit, computed combinationally to next_credit:
  - Accepted NONSEQ is HSELM & HTRANSM=NONSEQ & !no_port.
  - Each accepted NONSEQ gives credit_remain-1, saturating at 0.
  - exhausted = (next_credit==0).
- Round-robin search: scan ports owner+1, owner+2, ... modulo NUM_PORTS.
  - The owner index is examined last.
  - The first set req bit wins.
  - Wrap-around is modulo NUM_PORTS, not 2^PORT_W.
- Decision, in priority order:
  1. HMASTLOCKM | next_burst_hold: keep owner and its credit; no_port unchanged.
  2. no_port=1: search from addr_in_port+1 including all ports.
     - If found: grant that port, no_port=0, credit=weight[new]+1.
     - Else: stay no_port=1, addr_in_port kept.
  3. Owner active and !exhausted and HSELM: keep owner, credit=next_credit.
  4. Otherwise, if any other port requests: grant the first found, credit=weight[new]+1.
  5. Otherwise, if HSELM: keep owner, credit reloaded to weight[owner]+1.
  6. Otherwise: no_port=1, addr_in_port kept, credit=0.
- Weight 0 gives 1 credit; weight 15 gives 16 credits.
- weight_cfg changes take effect only at the next credit load.
- Unused req bits above NUM_PORTS-1 are not present.

## Timing
- All outputs are registered and update on the HCLK rising edge only when HREADYM=1.
- When HREADYM=0, every register, including the burst and credit counters, is frozen.
- Decision inputs are sampled in the address phase. The new grant is visible on addr_in_port one cycle later: 1-cycle arbitration latency.
- An ownership change occurs only on HREADYM=1 edges, so it always aligns with a transfer boundary.
- Simultaneous owner NONSEQ and competing request at credit 1: the NONSEQ is counted, credit reaches 0, and the grant moves at the same edge.
- Reset asserted mid-burst: all state returns to reset values immediately, with no grant preserved.

## Test plan
- Reset, then req=4'b0110 with weights 0: addr_in_port=1 and no_port=0 one cycle after the first HREADYM edge; after one accepted NONSEQ, the grant moves to port 2.
- Port 0 weight 3, req=4'b0011 continuously, singles: port 0 holds for exactly 4 NONSEQs, port 1 for 1, and the pattern repeats.
- Port 3 owner, req=4'b1001, weight 0, INCR8 issued: the grant stays on port 3 through 8 beats including BUSY cycles, then moves to port 0, exercising wrap 3→0.
- HMASTLOCKM=1 on port 1 with credit exhausted and req=4'b1111: the grant is held until HMASTLOCKM=0, then moves to port 2.
- HREADYM=0 for 5 cycles while req changes: addr_in_port, no_port and credit_remain are unchanged.
- All req=0 and HSELM=0: no_port=1 and addr_in_port retains its last value; reset asserted during a WRAP16 gives no_port=1, addr_in_port=0, credit_remain=0.

Source files
------------

// File: rtl/ahb_wrr_output_arbiter.sv
// Weighted round-robin output arbiter for one AHB bus-matrix output stage.
// Each grant carries a NONSEQ credit budget; bursts and locked sequences are never split.
module ahb_wrr_output_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 3,
    parameter int WEIGHT_W  = 4
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS*WEIGHT_W-1:0] weight_cfg,
    input  logic                          HREADYM,
    input  logic                          HSELM,
    input  logic [1:0]                    HTRANSM,
    input  logic [2:0]                    HBURSTM,
    input  logic                          HMASTLOCKM,
    output logic [PORT_W-1:0]             addr_in_port,
    output logic                          no_port,
    output logic [WEIGHT_W:0]             credit_remain
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] BU_SINGLE = 3'd0;
    localparam logic [2:0] BU_WRAP8  = 3'd4;
    localparam logic [2:0] BU_INCR8  = 3'd5;
    localparam logic [2:0] BU_WRAP16 = 3'd6;
    localparam logic [2:0] BU_INCR16 = 3'd7;

    localparam logic [WEIGHT_W:0] CREDIT_ONE = (WEIGHT_W+1)'(1);

    logic [3:0]          burst_remain, next_burst_remain;
    logic                burst_hold, next_burst_hold;
    logic                accepted, exhausted;
    logic [WEIGHT_W:0]   next_credit;
    logic [PORT_W:0]     scan_all, scan_other;
    logic [PORT_W-1:0]   next_addr;
    logic                next_no_port;
    logic [WEIGHT_W:0]   next_credit_q;

    // Scans owner+1, owner+2, ... (mod NUM_PORTS) over 'span' ports; MSB of result flags a hit.
    function automatic logic [PORT_W:0] find_next(input logic [NUM_PORTS-1:0] r,
                                                  input logic [PORT_W-1:0]    owner,
                                                  input int                   span);
        logic [PORT_W:0]      res;
        logic [NUM_PORTS-1:0] sh;
        int                   p;
        res = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            p  = (int'(owner) + k) % NUM_PORTS;
            sh = r >> p;
            if (k <= span && sh[0]) begin
                res = {1'b1, PORT_W'(p)};
            end
        end
        return res;
    endfunction

    function automatic logic [WEIGHT_W:0] credit_load(input logic [NUM_PORTS*WEIGHT_W-1:0] w,
                                                      input logic [PORT_W-1:0]             idx);
        logic [NUM_PORTS*WEIGHT_W-1:0] sh;
        sh = w >> (int'(idx) * WEIGHT_W);
        return {1'b0, sh[WEIGHT_W-1:0]} + CREDIT_ONE;
    endfunction

    // Burst tracking: short INCR is treated like a 4-beat burst so it is never split.
    always_comb begin
        next_burst_remain = burst_remain;
        next_burst_hold   = burst_hold;
        if (!HSELM || HTRANSM == TR_IDLE) begin
            next_burst_remain = '0;
            next_burst_hold   = 1'b0;
        end else if (HTRANSM == TR_NONSEQ) begin
            next_burst_hold = 1'b1;
            case (HBURSTM)
                BU_WRAP16, BU_INCR16: next_burst_remain = 4'd14;
                BU_WRAP8,  BU_INCR8:  next_burst_remain = 4'd6;
                BU_SINGLE: begin
                    next_burst_remain = 4'd0;
                    next_burst_hold   = 1'b0;
                end
                default:              next_burst_remain = 4'd2;
            endcase
        end else if (HTRANSM == TR_SEQ) begin
            if (burst_remain == 4'd0) begin
                next_burst_hold = 1'b0;
            end else begin
                next_burst_remain = burst_remain - 4'd1;
            end
        end
    end

    assign accepted    = HSELM && (HTRANSM == TR_NONSEQ) && !no_port;
    assign next_credit = (accepted && credit_remain != '0) ? credit_remain - CREDIT_ONE
                                                           : credit_remain;
    assign exhausted   = (next_credit == '0);

    assign scan_all   = find_next(req, addr_in_port, NUM_PORTS);
    assign scan_other = find_next(req, addr_in_port, NUM_PORTS - 1);

    always_comb begin
        next_addr     = addr_in_port;
        next_no_port  = no_port;
        next_credit_q = next_credit;
        if (HMASTLOCKM || next_burst_hold) begin
            next_credit_q = next_credit;
        end else if (no_port) begin
            if (scan_all[PORT_W]) begin
                next_addr     = scan_all[PORT_W-1:0];
                next_no_port  = 1'b0;
                next_credit_q = credit_load(weight_cfg, scan_all[PORT_W-1:0]);
            end
        end else if (!exhausted && HSELM) begin
            next_credit_q = next_credit;
        end else if (scan_other[PORT_W]) begin
            next_addr     = scan_other[PORT_W-1:0];
            next_credit_q = credit_load(weight_cfg, scan_other[PORT_W-1:0]);
        end else if (HSELM) begin
            next_credit_q = credit_load(weight_cfg, addr_in_port);
        end else begin
            next_no_port  = 1'b1;
            next_credit_q = '0;
        end
    end

    // HREADYM low freezes everything so ownership only changes on transfer boundaries.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_in_port  <= '0;
            no_port       <= 1'b1;
            credit_remain <= '0;
            burst_remain  <= '0;
            burst_hold    <= 1'b0;
        end else if (HREADYM) begin
            addr_in_port  <= next_addr;
            no_port       <= next_no_port;
            credit_remain <= next_credit_q;
            burst_remain  <= next_burst_remain;
            burst_hold    <= next_burst_hold;
        end
    end

endmodule

// File: tb/tb_ahb_wrr_output_arbiter.sv
// Scoreboard bench for ahb_wrr_output_arbiter: a beat-counting reference model pushes
// expected outputs per cycle, and an independent monitor pops and compares them.
module tb_ahb_wrr_output_arbiter;

    localparam int NP = 4;
    localparam int PW = 3;
    localparam int WW = 4;

    logic             HCLK = 1'b0;
    logic             HRESETn = 1'b0;
    logic [NP-1:0]    req = '0;
    logic [NP*WW-1:0] weight_cfg = '0;
    logic             HREADYM = 1'b1;
    logic             HSELM = 1'b0;
    logic [1:0]       HTRANSM = 2'b00;
    logic [2:0]       HBURSTM = 3'b000;
    logic             HMASTLOCKM = 1'b0;
    logic [PW-1:0]    addr_in_port;
    logic             no_port;
    logic [WW:0]      credit_remain;

    ahb_wrr_output_arbiter #(.NUM_PORTS(NP), .PORT_W(PW), .WEIGHT_W(WW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .weight_cfg(weight_cfg),
        .HREADYM(HREADYM), .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM),
        .HMASTLOCKM(HMASTLOCKM), .addr_in_port(addr_in_port), .no_port(no_port),
        .credit_remain(credit_remain)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [PW-1:0] addr;
        logic          idle;
        logic [WW:0]   credit;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic             s_rstn = 1'b0;
    logic [NP-1:0]    s_req = '0;
    logic [NP*WW-1:0] s_w = '0;
    logic             s_ready = 1'b1;
    logic             s_sel = 1'b0;
    logic [1:0]       s_trans = 2'b00;
    logic [2:0]       s_burst = 3'b000;
    logic             s_lock = 1'b0;

    // Model state: owner, idle flag, credits left, and SEQ beats still owed by the burst.
    int m_owner  = 0;
    bit m_idle   = 1'b1;
    int m_credit = 0;
    int m_beats  = 0;

    function automatic int burst_len(input logic [2:0] b);
        case (b)
            3'd0:       return 1;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 4;
        endcase
    endfunction

    function automatic int weight_of(input int p);
        logic [NP*WW-1:0] t;
        t = s_w >> (p * WW);
        return int'(t[WW-1:0]);
    endfunction

    function automatic int pick(input int owner, input int span);
        logic [NP-1:0] sh;
        for (int k = 1; k <= span; k++) begin
            sh = s_req >> ((owner + k) % NP);
            if (sh[0]) return (owner + k) % NP;
        end
        return -1;
    endfunction

    task automatic applyStimulus();
        int   nc, nb, pa, po;
        bit   acc;
        exp_t e;
        @(negedge HCLK);
        HRESETn    = s_rstn;
        req        = s_req;
        weight_cfg = s_w;
        HREADYM    = s_ready;
        HSELM      = s_sel;
        HTRANSM    = s_trans;
        HBURSTM    = s_burst;
        HMASTLOCKM = s_lock;
        if (!s_rstn) begin
            m_owner = 0; m_idle = 1'b1; m_credit = 0; m_beats = 0;
        end else if (s_ready) begin
            acc = s_sel && s_trans == 2'b10 && !m_idle;
            nc  = (acc && m_credit > 0) ? m_credit - 1 : m_credit;
            if (!s_sel || s_trans == 2'b00)  nb = 0;
            else if (s_trans == 2'b10)       nb = burst_len(s_burst) - 1;
            else if (s_trans == 2'b11)       nb = (m_beats > 0) ? m_beats - 1 : 0;
            else                             nb = m_beats;
            pa = pick(m_owner, NP);
            po = pick(m_owner, NP - 1);
            if (s_lock || nb > 0) begin
                m_credit = nc;
            end else if (m_idle) begin
                if (pa >= 0) begin
                    m_owner = pa; m_idle = 1'b0; m_credit = weight_of(pa) + 1;
                end else begin
                    m_credit = nc;
                end
            end else if (nc > 0 && s_sel) begin
                m_credit = nc;
            end else if (po >= 0) begin
                m_owner = po; m_credit = weight_of(po) + 1;
            end else if (s_sel) begin
                m_credit = weight_of(m_owner) + 1;
            end else begin
                m_idle = 1'b1; m_credit = 0;
            end
            m_beats = nb;
        end
        e.addr   = m_owner[PW-1:0];
        e.idle   = m_idle;
        e.credit = m_credit[WW:0];
        sb_q.push_back(e);
    endtask

    task automatic run(input int n);
        repeat (n) applyStimulus();
    endtask

    task automatic checkOutput(input exp_t e);
        n_cmp++;
        if (addr_in_port !== e.addr) begin
            n_fail++;
            $display("[TB] FAIL addr_in_port: got %0d expected %0d at %0t", addr_in_port, e.addr, $time);
        end
        n_cmp++;
        if (no_port !== e.idle) begin
            n_fail++;
            $display("[TB] FAIL no_port: got %0b expected %0b at %0t", no_port, e.idle, $time);
        end
        n_cmp++;
        if (credit_remain !== e.credit) begin
            n_fail++;
            $display("[TB] FAIL credit_remain: got %0d expected %0d at %0t", credit_remain, e.credit, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge HCLK);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        s_rstn = 1'b0; run(2);
        s_rstn = 1'b1;
        s_req = 4'b0110; s_w = '0; s_sel = 1'b1; s_trans = 2'b00; run(1);
        s_trans = 2'b10; s_burst = 3'd0; run(2);
        s_w = 16'h0003; s_req = 4'b0011; run(12);

        s_w = '0; s_req = 4'b1000; s_sel = 1'b0; s_trans = 2'b00; run(3);
        s_sel = 1'b1; s_req = 4'b1001; s_trans = 2'b10; s_burst = 3'd5; run(1);
        s_trans = 2'b11; run(3);
        s_trans = 2'b01; run(2);
        s_trans = 2'b11; run(4);
        s_trans = 2'b00; run(2);

        s_req = 4'b0010; s_sel = 1'b0; run(3);
        s_sel = 1'b1; s_lock = 1'b1; s_req = 4'b1111; s_trans = 2'b10; s_burst = 3'd0; run(4);
        s_lock = 1'b0; run(2);

        s_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_req = NP'($urandom);
            run(1);
        end
        s_ready = 1'b1;

        s_req = '0; s_sel = 1'b0; s_trans = 2'b00; run(3);
        s_req = 4'b0100; s_sel = 1'b1; run(2);
        s_trans = 2'b10; s_burst = 3'd6; run(1);
        s_trans = 2'b11; run(3);
        s_rstn = 1'b0; run(1);
        s_rstn = 1'b1; run(2);

        for (int i = 0; i < 3000; i++) begin
            s_rstn  = ($urandom_range(0, 400) != 0);
            if ($urandom_range(0, 3) == 0)  s_req = NP'($urandom);
            if ($urandom_range(0, 50) == 0) s_w = (NP*WW)'($urandom);
            s_ready = ($urandom_range(0, 7) != 0);
            s_sel   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 20) == 0) s_lock = ~s_lock;
            s_burst = 3'($urandom);
            if ($urandom_range(0, 15) == 0)  s_trans = 2'($urandom);
            else if (m_beats > 0)            s_trans = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b11;
            else                             s_trans = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'b10;
            run(1);
        end

        repeat (3) @(posedge HCLK);
        #2;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
